pipeline_stall_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage pipeline. Consumes `is_data_hazard` from the F/D-stage hazard detector, the D/X instruction word, the X-stage branch/jump redirect, and the multiplier/divider completion handshake. Produces the latch enables, bubble and flush controls for PC, F/D, D/X and X/M, plus the multdiv start pulse. Runs a 2-state FSM that freezes the front of the pipeline for the duration of a multi-cycle mul/div, and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/sat_counter.sv | 19 +
 rtl/pipeline_stall_ctrl.sv | 101 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcode/ALU-op fields, FSM state type and the mul/div decode helper.
package pipe_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;

    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    typedef enum logic {RUN, MD_WAIT} stall_state_t;

    function automatic logic is_multdiv(input logic [31:0] insn);
        return (insn[31:27] == OP_RTYPE) &&
               ((insn[6:2] == ALU_MUL) || (insn[6:2] == ALU_DIV));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush controller: branch flush, load-use hazard bubbles and multi-cycle mul/div freeze.
module pipeline_stall_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             is_data_hazard,
    input  logic [31:0]      dx_insn,
    input  logic             branch_taken,
    input  logic             multdiv_ready,
    output logic             pc_en,
    output logic             fd_en,
    output logic             dx_en,
    output logic             xm_en,
    output logic             fd_flush,
    output logic             dx_bubble,
    output logic             xm_bubble,
    output logic             multdiv_start,
    output logic [CNT_W-1:0] stall_count
);

    stall_state_t state_q, state_d;
    logic         dx_is_md;

    assign dx_is_md = is_multdiv(dx_insn);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_en         = 1'b0;
        fd_en         = 1'b0;
        dx_en         = 1'b0;
        xm_en         = 1'b0;
        fd_flush      = 1'b0;
        dx_bubble     = 1'b0;
        xm_bubble     = 1'b0;
        multdiv_start = 1'b0;
        if (!reset) begin
            pc_en = 1'b1;
            fd_en = 1'b1;
            dx_en = 1'b1;
            xm_en = 1'b1;
            unique case (state_q)
                RUN: begin
                    // A redirect squashes whatever is in F/D and D/X, so it outranks both stalls.
                    if (branch_taken) begin
                        fd_flush  = 1'b1;
                        dx_bubble = 1'b1;
                    end else if (dx_is_md) begin
                        multdiv_start = 1'b1;
                        pc_en         = 1'b0;
                        fd_en         = 1'b0;
                        dx_en         = 1'b0;
                        xm_bubble     = 1'b1;
                        state_d       = MD_WAIT;
                    end else if (is_data_hazard) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_bubble = 1'b1;
                    end
                end
                MD_WAIT: begin
                    if (!multdiv_ready) begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        dx_en     = 1'b0;
                        xm_bubble = 1'b1;
                    end else begin
                        // Release: X/M takes the result while the hazard check still applies up front.
                        if (is_data_hazard) begin
                            pc_en     = 1'b0;
                            fd_en     = 1'b0;
                            dx_bubble = 1'b1;
                        end
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clock(clock),
        .reset(reset),
        .inc  (!pc_en && !reset),
        .count(stall_count)
    );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed self-checking bench for pipeline_stall_ctrl, with a CNT_W=4 copy for saturation.
module tb_pipeline_stall_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        is_data_hazard = 1'b0;
    logic [31:0] dx_insn = 32'h0;
    logic        branch_taken = 1'b0;
    logic        multdiv_ready = 1'b0;

    logic        pc_en, fd_en, dx_en, xm_en, fd_flush, dx_bubble, xm_bubble, multdiv_start;
    logic [31:0] stall_count;
    logic        pc_en4, fd_en4, dx_en4, xm_en4, fd_flush4, dx_bubble4, xm_bubble4, start4;
    logic [3:0]  stall_count4;
    logic [7:0]  ctl;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] ADDI = 32'h28C00005;
    localparam logic [31:0] MUL  = 32'h00C41018;
    localparam logic [31:0] DIV  = 32'h00C4101C;

    // {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_bubble, xm_bubble, multdiv_start}
    localparam logic [7:0] C_RUN  = 8'b1111_0000;
    localparam logic [7:0] C_HAZ  = 8'b0011_0100;
    localparam logic [7:0] C_MDST = 8'b0001_0011;
    localparam logic [7:0] C_MDW  = 8'b0001_0010;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_OFF  = 8'b0000_0000;

    assign ctl = {pc_en, fd_en, dx_en, xm_en, fd_flush, dx_bubble, xm_bubble, multdiv_start};

    always #5 clock = ~clock;

    pipeline_stall_ctrl #(.CNT_W(32)) dut (
        .clock(clock), .reset(reset), .is_data_hazard(is_data_hazard), .dx_insn(dx_insn),
        .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
        .pc_en(pc_en), .fd_en(fd_en), .dx_en(dx_en), .xm_en(xm_en), .fd_flush(fd_flush),
        .dx_bubble(dx_bubble), .xm_bubble(xm_bubble), .multdiv_start(multdiv_start),
        .stall_count(stall_count)
    );

    pipeline_stall_ctrl #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .is_data_hazard(is_data_hazard), .dx_insn(dx_insn),
        .branch_taken(branch_taken), .multdiv_ready(multdiv_ready),
        .pc_en(pc_en4), .fd_en(fd_en4), .dx_en(dx_en4), .xm_en(xm_en4), .fd_flush(fd_flush4),
        .dx_bubble(dx_bubble4), .xm_bubble(xm_bubble4), .multdiv_start(start4),
        .stall_count(stall_count4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        is_data_hazard = 1'b1;
        dx_insn = MUL;
        #3;
        checks++;
        if (ctl !== C_OFF) begin
            errors++;
            $display("FAIL reset_outputs: got %b want %b", ctl, C_OFF);
        end
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d want 0", stall_count);
        end
        is_data_hazard = 1'b0;
        dx_insn = 32'h0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL reset_first_run: got %b want %b", ctl, C_RUN);
        end
        tick();
    endtask

    task automatic test_hazard();
        dx_insn = ADDI;
        is_data_hazard = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (ctl !== C_HAZ) begin
                errors++;
                $display("FAIL hazard_cycle%0d: got %b want %b", i, ctl, C_HAZ);
            end
            tick();
        end
        is_data_hazard = 1'b0;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL hazard_end: got %b want %b", ctl, C_RUN);
        end
        checks++;
        if (stall_count !== 32'd2) begin
            errors++;
            $display("FAIL hazard_count: got %0d want 2", stall_count);
        end
        tick();
    endtask

    task automatic test_mul();
        dx_insn = MUL;
        #1;
        checks++;
        if (ctl !== C_MDST) begin
            errors++;
            $display("FAIL mul_start: got %b want %b", ctl, C_MDST);
        end
        tick();
        // four wait cycles; branch/hazard thrown in on one of them must be ignored
        for (int i = 0; i < 4; i++) begin
            branch_taken = (i == 1);
            is_data_hazard = (i == 1);
            #1;
            checks++;
            if (ctl !== C_MDW) begin
                errors++;
                $display("FAIL mul_wait%0d: got %b want %b", i, ctl, C_MDW);
            end
            tick();
        end
        branch_taken = 1'b0;
        is_data_hazard = 1'b0;
        multdiv_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL mul_release: got %b want %b", ctl, C_RUN);
        end
        tick();
        multdiv_ready = 1'b0;
        dx_insn = ADDI;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL mul_after: got %b want %b", ctl, C_RUN);
        end
        checks++;
        if (stall_count !== 32'd7) begin
            errors++;
            $display("FAIL mul_count: got %0d want 7", stall_count);
        end
        tick();
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        is_data_hazard = 1'b1;
        dx_insn = DIV;
        #1;
        checks++;
        if (ctl !== C_BR) begin
            errors++;
            $display("FAIL branch_priority: got %b want %b", ctl, C_BR);
        end
        tick();
        branch_taken = 1'b0;
        is_data_hazard = 1'b0;
        dx_insn = ADDI;
        multdiv_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL ready_ignored_in_run: got %b want %b", ctl, C_RUN);
        end
        checks++;
        if (stall_count !== 32'd7) begin
            errors++;
            $display("FAIL branch_count: got %0d want 7", stall_count);
        end
        tick();
        multdiv_ready = 1'b0;
    endtask

    task automatic test_release_hazard();
        dx_insn = DIV;
        #1;
        checks++;
        if (ctl !== C_MDST) begin
            errors++;
            $display("FAIL relhaz_start: got %b want %b", ctl, C_MDST);
        end
        tick();
        multdiv_ready = 1'b1;
        is_data_hazard = 1'b1;
        #1;
        checks++;
        if (ctl !== C_HAZ) begin
            errors++;
            $display("FAIL relhaz_release: got %b want %b", ctl, C_HAZ);
        end
        tick();
        multdiv_ready = 1'b0;
        is_data_hazard = 1'b0;
        dx_insn = ADDI;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL relhaz_back_to_run: got %b want %b", ctl, C_RUN);
        end
        checks++;
        if (stall_count !== 32'd9) begin
            errors++;
            $display("FAIL relhaz_count: got %0d want 9", stall_count);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        dx_insn = MUL;
        tick();
        multdiv_ready = 1'b1;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL b2b_release: got %b want %b", ctl, C_RUN);
        end
        tick();
        multdiv_ready = 1'b0;
        #1;
        checks++;
        if (ctl !== C_MDST) begin
            errors++;
            $display("FAIL b2b_second_start: got %b want %b", ctl, C_MDST);
        end
        checks++;
        if (stall_count !== 32'd10) begin
            errors++;
            $display("FAIL b2b_count: got %0d want 10", stall_count);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        // DUT is now in MD_WAIT from the second back-to-back start
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ctl !== C_OFF) begin
            errors++;
            $display("FAIL midreset_outputs: got %b want %b", ctl, C_OFF);
        end
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_count: got %0d want 0", stall_count);
        end
        #1;
        reset = 1'b0;
        dx_insn = ADDI;
        #1;
        checks++;
        if (ctl !== C_RUN) begin
            errors++;
            $display("FAIL midreset_state_run: got %b want %b", ctl, C_RUN);
        end
        tick();
        checks++;
        if (stall_count !== 32'd0) begin
            errors++;
            $display("FAIL midreset_count_after: got %0d want 0", stall_count);
        end
    endtask

    task automatic test_saturation();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        dx_insn = ADDI;
        is_data_hazard = 1'b1;
        repeat (20) tick();
        checks++;
        if (stall_count4 !== 4'd15) begin
            errors++;
            $display("FAIL sat_count4: got %0d want 15", stall_count4);
        end
        checks++;
        if (stall_count !== 32'd20) begin
            errors++;
            $display("FAIL sat_count32: got %0d want 20", stall_count);
        end
        is_data_hazard = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_hazard();
        test_mul();
        test_branch();
        test_release_hazard();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
